bsg_wormhole_packet_assembler: RTL and testbench

BSG_WORMHOLE_PACKET_ASSEMBLER -- requirements
Module: bsg_wormhole_packet_assembler

---
 rtl/bsg_chip_pkg.sv | 16 +
 rtl/bsg_counter_clear_up.sv | 27 ++
 rtl/bsg_wormhole_packet_assembler.sv | 131 +++++++++++++
 tb/tb_bsg_wormhole_packet_assembler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_chip_pkg.sv
// Chip-wide wormhole constants and the header layout shared by wormhole endpoints.
// Header fields are packed cid (MSB) .. len .. cord (LSB) at the bottom of a flit.
package bsg_chip_pkg;

    localparam int wh_flit_width_gp = 16;
    localparam int wh_len_width_gp  = 4;
    localparam int wh_cid_width_gp  = 2;
    localparam int wh_cord_width_gp = 5;

    typedef struct packed {
        logic [wh_cid_width_gp-1:0]  cid;
        logic [wh_len_width_gp-1:0]  len;
        logic [wh_cord_width_gp-1:0] cord;
    } bsg_wh_header_s;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear wins over up.
module bsg_counter_clear_up #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] r_count;

    // Count register: async reset, then clear, then increment.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (up_i) begin
            r_count <= r_count + width_p'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/bsg_wormhole_packet_assembler.sv
// Collects a wormhole header plus its body flits into one wide packet and
// presents it to the consumer; body flits beyond the stored slots are dropped.
module bsg_wormhole_packet_assembler
    import bsg_chip_pkg::*;
#(
    parameter int          flit_width_p        = wh_flit_width_gp,
    parameter int          len_width_p         = wh_len_width_gp,
    parameter int          cid_width_p         = wh_cid_width_gp,
    parameter int          cord_width_p        = wh_cord_width_gp,
    parameter int unsigned max_payload_flits_p = 4
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        v_i,
    input  logic [flit_width_p-1:0]                     data_i,
    output logic                                        ready_and_o,
    output logic                                        v_o,
    output logic [flit_width_p-1:0]                     header_o,
    output logic [max_payload_flits_p*flit_width_p-1:0] payload_o,
    input  logic                                        ready_and_i,
    output logic                                        err_o
);

    localparam int hdr_width_lp = cord_width_p + len_width_p + cid_width_p;

    typedef enum logic [1:0] {eHeader, eBody, eSend} state_e;

    state_e                    r_state;
    logic [len_width_p-1:0]    r_len;
    logic [flit_width_p-1:0]   r_header;
    logic [flit_width_p-1:0]   r_slots [max_payload_flits_p];
    logic                      r_v;
    logic                      r_err;

    logic                      w_ready;
    logic                      w_accept;
    logic                      w_clear;
    logic                      w_up;
    logic                      w_last;
    logic                      w_in_range;
    logic [len_width_p-1:0]    w_count;
    logic [len_width_p-1:0]    w_hdr_len;

    // Not ready while reset is held so nothing is taken during reset.
    assign w_ready    = (r_state != eSend) && !reset_i;
    assign w_accept   = v_i && w_ready;
    assign w_hdr_len  = data_i[hdr_width_lp-cid_width_p-1 -: len_width_p];
    assign w_clear    = w_accept && (r_state == eHeader);
    assign w_up       = w_accept && (r_state == eBody);
    assign w_last     = (w_count == (r_len - len_width_p'(1)));
    assign w_in_range = (32'(w_count) < max_payload_flits_p);

    bsg_counter_clear_up #(
        .width_p (len_width_p)
    ) flit_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_clear),
        .up_i    (w_up),
        .count_o (w_count)
    );

    // Packet FSM with registered header, payload slots, valid and sticky error.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= eHeader;
            r_len    <= '0;
            r_header <= '0;
            r_v      <= 1'b0;
            r_err    <= 1'b0;
            for (int unsigned i = 0; i < max_payload_flits_p; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            case (r_state)
                eHeader: begin
                    if (w_accept) begin
                        r_header <= data_i;
                        r_len    <= w_hdr_len;
                        for (int unsigned i = 0; i < max_payload_flits_p; i++) begin
                            r_slots[i] <= '0;
                        end
                        if (w_hdr_len == '0) begin
                            r_state <= eSend;
                            r_v     <= 1'b1;
                        end else begin
                            r_state <= eBody;
                        end
                    end
                end
                eBody: begin
                    if (w_accept) begin
                        if (w_in_range) begin
                            for (int unsigned i = 0; i < max_payload_flits_p; i++) begin
                                if (32'(w_count) == i) begin
                                    r_slots[i] <= data_i;
                                end
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= eSend;
                            r_v     <= 1'b1;
                        end
                    end
                end
                eSend: begin
                    if (ready_and_i) begin
                        r_state <= eHeader;
                        r_v     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= eHeader;
                    r_v     <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < max_payload_flits_p; g++) begin : g_payload
        assign payload_o[g*flit_width_p +: flit_width_p] = r_slots[g];
    end

    assign ready_and_o = w_ready;
    assign v_o         = r_v;
    assign header_o    = r_header;
    assign err_o       = r_err;

endmodule

// File: tb/tb_bsg_wormhole_packet_assembler.sv
// Directed bench for the wormhole packet assembler: header-only, gapped body,
// consumer stall, overflow with sticky error, and mid-packet reset.
module tb_bsg_wormhole_packet_assembler;

    logic        clk;
    logic        reset_i;
    logic        v_i;
    logic [15:0] data_i;
    logic        ready_and_o;
    logic        v_o;
    logic [15:0] header_o;
    logic [63:0] payload_o;
    logic        ready_and_i;
    logic        err_o;

    int vecs;
    int miscompares;

    bsg_wormhole_packet_assembler dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .data_i      (data_i),
        .ready_and_o (ready_and_o),
        .v_o         (v_o),
        .header_o    (header_o),
        .payload_o   (payload_o),
        .ready_and_i (ready_and_i),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vecs        = 0;
        miscompares = 0;
        reset_i     = 1'b1;
        v_i         = 1'b0;
        data_i      = 16'h0000;
        ready_and_i = 1'b0;

        // reset state
        #3;
        check("rst_v",   64'(v_o),         64'h0);
        check("rst_rdy", 64'(ready_and_o), 64'h0);
        check("rst_hdr", 64'(header_o),    64'h0);
        check("rst_pay", payload_o,        64'h0);
        check("rst_err", 64'(err_o),       64'h0);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("idle_rdy", 64'(ready_and_o), 64'h1);

        // header-only packet: cid=1 len=0 cord=5
        @(negedge clk);
        v_i    = 1'b1;
        data_i = 16'hA205;
        @(negedge clk);
        v_i = 1'b0;
        check("h0_v",   64'(v_o),         64'h1);
        check("h0_hdr", 64'(header_o),    64'hA205);
        check("h0_pay", payload_o,        64'h0);
        check("h0_rdy", 64'(ready_and_o), 64'h0);
        @(negedge clk);
        check("h0_hold_v", 64'(v_o), 64'h1);
        ready_and_i = 1'b1;
        @(negedge clk);
        ready_and_i = 1'b0;
        check("h0_done_v",   64'(v_o),         64'h0);
        check("h0_done_rdy", 64'(ready_and_o), 64'h1);

        // len=3 with two idle cycles between body flits
        v_i    = 1'b1;
        data_i = 16'h0463;
        @(negedge clk);
        data_i = 16'h1111;
        @(negedge clk);
        v_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        v_i    = 1'b1;
        data_i = 16'h2222;
        @(negedge clk);
        v_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("gap_mid_v", 64'(v_o), 64'h0);
        v_i    = 1'b1;
        data_i = 16'h3333;
        @(negedge clk);
        v_i = 1'b0;
        check("gap_v",   64'(v_o),      64'h1);
        check("gap_hdr", 64'(header_o), 64'h0463);
        check("gap_pay", payload_o,     64'h0000_3333_2222_1111);
        check("gap_err", 64'(err_o),    64'h0);

        // consumer stalls 10 cycles while junk flits are offered
        v_i    = 1'b1;
        data_i = 16'hDEAD;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_v",   64'(v_o),         64'h1);
            check("stall_rdy", 64'(ready_and_o), 64'h0);
            check("stall_pay", payload_o,        64'h0000_3333_2222_1111);
            check("stall_hdr", 64'(header_o),    64'h0463);
        end
        v_i         = 1'b0;
        ready_and_i = 1'b1;
        @(negedge clk);
        ready_and_i = 1'b0;
        check("rel_rdy", 64'(ready_and_o), 64'h1);
        v_i    = 1'b1;
        data_i = 16'h0025;
        @(negedge clk);
        data_i = 16'h4444;
        @(negedge clk);
        v_i = 1'b0;
        check("rel_v",   64'(v_o),      64'h1);
        check("rel_hdr", 64'(header_o), 64'h0025);
        check("rel_pay", payload_o,     64'h0000_0000_0000_4444);
        ready_and_i = 1'b1;
        @(negedge clk);
        ready_and_i = 1'b0;

        // len=6 overflows four slots
        v_i    = 1'b1;
        data_i = 16'h00C1;
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            data_i = {k[7:0], k[7:0]};
            @(negedge clk);
            if (k == 4) check("ovf_err_pre", 64'(err_o), 64'h0);
        end
        v_i = 1'b0;
        check("ovf_v",   64'(v_o),   64'h1);
        check("ovf_pay", payload_o,  64'h0404_0303_0202_0101);
        check("ovf_err", 64'(err_o), 64'h1);
        ready_and_i = 1'b1;
        @(negedge clk);
        ready_and_i = 1'b0;
        v_i    = 1'b1;
        data_i = 16'h0007;
        @(negedge clk);
        v_i = 1'b0;
        check("sticky_v",   64'(v_o),   64'h1);
        check("sticky_pay", payload_o,  64'h0);
        check("sticky_err", 64'(err_o), 64'h1);
        ready_and_i = 1'b1;
        @(negedge clk);
        ready_and_i = 1'b0;

        // reset after two of three body flits
        v_i    = 1'b1;
        data_i = 16'h0063;
        @(negedge clk);
        data_i = 16'h0A0A;
        @(negedge clk);
        data_i = 16'h0B0B;
        @(negedge clk);
        v_i = 1'b0;
        check("part_pay", payload_o, 64'h0000_0000_0B0B_0A0A);
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_v",   64'(v_o),         64'h0);
        check("arst_pay", payload_o,        64'h0);
        check("arst_hdr", 64'(header_o),    64'h0);
        check("arst_rdy", 64'(ready_and_o), 64'h0);
        check("arst_err", 64'(err_o),       64'h0);
        @(negedge clk);
        reset_i = 1'b0;
        v_i     = 1'b1;
        data_i  = 16'h0022;
        @(negedge clk);
        data_i = 16'h5555;
        @(negedge clk);
        v_i = 1'b0;
        check("post_v",   64'(v_o),      64'h1);
        check("post_hdr", 64'(header_o), 64'h0022);
        check("post_pay", payload_o,     64'h0000_0000_0000_5555);
        check("post_err", 64'(err_o),    64'h0);
        ready_and_i = 1'b1;
        @(negedge clk);
        ready_and_i = 1'b0;
        check("post_done_v", 64'(v_o), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
